// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Drives an in-place radix-2 DIT FFT over a 2^FFT_N-point complex RAM.
//   It runs FFT_N stages. In each stage it issues one butterfly per cycle,
//   maps the returned butterfly indices back to RAM write addresses, and
//   tracks the block-floating-point width that the next stage will apply.
//
//   Ports
//     clk, reset            clock, asynchronous active-low reset
//     start                 one-cycle run request (honoured only when idle)
//     busy / done / err     run in progress / end-of-run pulse / sticky protocol error
//     stage                 current stage index
//     rd_en, rd_addr_a/b    RAM operand reads
//     tw_addr               twiddle ROM index
//     bf_iact/ictrl/addr    butterfly issue, aligned to read data by RD_LATENCY
//     bf_clr_bfp, bf_ibfp   stage-start pulse and BFP width for the stage
//     bf_oact/octrl/oaddr   butterfly results returning from the core
//     bf_max_bit_width      result width, valid with bf_oact
//     wr_en, wr_addr_a/b    RAM result writes (combinational from the return path)
module fft_stage_sequencer #(
   parameter int unsigned FFT_N             = 10,
   parameter int unsigned FFT_MAX_BIT_WIDTH = 5,
   parameter int unsigned RD_LATENCY        = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [FFT_N-1:0]             stage,
   output logic                         rd_en,
   output logic [FFT_N-1:0]             rd_addr_a,
   output logic [FFT_N-1:0]             rd_addr_b,
   output logic [FFT_N-2:0]             tw_addr,
   output logic                         bf_iact,
   output logic [1:0]                   bf_ictrl,
   output logic [FFT_N-2:0]             bf_addr,
   output logic                         bf_clr_bfp,
   output logic [FFT_MAX_BIT_WIDTH-1:0] bf_ibfp,
   input  logic                         bf_oact,
   input  logic [1:0]                   bf_octrl,
   input  logic [FFT_N-2:0]             bf_oaddr,
   input  logic [FFT_MAX_BIT_WIDTH-1:0] bf_max_bit_width,
   output logic                         wr_en,
   output logic [FFT_N-1:0]             wr_addr_a,
   output logic [FFT_N-1:0]             wr_addr_b
);

   localparam logic [FFT_N-1:0] ONE        = FFT_N'(1);
   localparam logic [FFT_N-2:0] K_ONE      = (FFT_N-1)'(1);
   localparam logic [FFT_N-2:0] K_LAST     = '1;
   localparam logic [FFT_N-1:0] HALF       = {1'b1, {(FFT_N-1){1'b0}}};
   localparam logic [FFT_N-1:0] RET_LAST   = HALF - ONE;
   localparam logic [FFT_N-1:0] LAST_STAGE = FFT_N'(FFT_N - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_NEXT, S_DONE} state_t;

   state_t                         state_q;
   logic [FFT_N-1:0]               stage_q;
   logic [FFT_N-2:0]               k_q;
   logic [FFT_N-1:0]               ret_q;
   logic [FFT_MAX_BIT_WIDTH-1:0]   smax_q;
   logic [FFT_MAX_BIT_WIDTH-1:0]   ibfp_q;
   logic                           busy_q, done_q, err_q, rd_en_q, clr_q;

   logic [RD_LATENCY-1:0]            act_q;
   logic [RD_LATENCY-1:0][1:0]       ctrl_q;
   logic [RD_LATENCY-1:0][FFT_N-2:0] kd_q;

   logic [1:0]          issue_ctrl_d;
   logic [FFT_N-2:0]    issue_k_d;
   logic [2*FFT_N-1:0]  rd_pair, wr_pair;
   logic                unused_octrl0;

   // A is k with a zero bit inserted at position s; B sets that bit.
   function automatic logic [2*FFT_N-1:0] pair_addr(input logic [FFT_N-2:0] k,
                                                    input logic [FFT_N-1:0] s);
      logic [FFT_N-1:0] kx, low, a;
      kx  = {1'b0, k};
      low = ~({FFT_N{1'b1}} << s);
      a   = ((kx & ~low) << 1) | (kx & low);
      return {a | (low + ONE), a};
   endfunction

   function automatic logic [FFT_N-2:0] tw_of(input logic [FFT_N-2:0] k,
                                              input logic [FFT_N-1:0] s);
      logic [FFT_N-2:0] pos;
      pos = k & ~({(FFT_N-1){1'b1}} << s);
      return pos << (LAST_STAGE - s);
   endfunction

   assign unused_octrl0 = bf_octrl[0];

   assign issue_ctrl_d = rd_en_q ? {k_q == K_LAST, k_q == '0} : 2'b00;
   assign issue_k_d    = rd_en_q ? k_q : '0;

   always_comb begin
      rd_pair   = pair_addr(k_q, stage_q);
      wr_pair   = pair_addr(bf_oaddr, stage_q);
      rd_addr_a = rd_en_q ? rd_pair[FFT_N-1:0] : '0;
      rd_addr_b = rd_en_q ? rd_pair[2*FFT_N-1:FFT_N] : '0;
      tw_addr   = rd_en_q ? tw_of(k_q, stage_q) : '0;
      wr_en     = bf_oact;
      wr_addr_a = bf_oact ? wr_pair[FFT_N-1:0] : '0;
      wr_addr_b = bf_oact ? wr_pair[2*FFT_N-1:FFT_N] : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         k_q     <= '0;
         ret_q   <= '0;
         smax_q  <= '0;
         ibfp_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_en_q <= 1'b0;
         clr_q   <= 1'b0;
         act_q   <= '0;
         ctrl_q  <= '0;
         kd_q    <= '0;
      end else begin
         act_q[0]  <= rd_en_q;
         ctrl_q[0] <= issue_ctrl_d;
         kd_q[0]   <= issue_k_d;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            act_q[i]  <= act_q[i-1];
            ctrl_q[i] <= ctrl_q[i-1];
            kd_q[i]   <= kd_q[i-1];
         end

         // Return accounting first so that the state-driven clears below win.
         if (bf_oact) begin
            ret_q <= ret_q + ONE;
            if (bf_max_bit_width > smax_q) smax_q <= bf_max_bit_width;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ISSUE;
                  stage_q <= '0;
                  k_q     <= '0;
                  ret_q   <= '0;
                  smax_q  <= '0;
                  ibfp_q  <= '0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  rd_en_q <= 1'b1;
                  clr_q   <= 1'b1;
               end
            end
            S_ISSUE: begin
               clr_q <= 1'b0;
               k_q   <= k_q + K_ONE;
               if (k_q == K_LAST) begin
                  state_q <= S_DRAIN;
                  rd_en_q <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (ret_q == HALF) begin
                  if (stage_q != LAST_STAGE) begin
                     state_q <= S_NEXT;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_NEXT: begin
               stage_q <= stage_q + ONE;
               ibfp_q  <= smax_q;
               smax_q  <= '0;
               ret_q   <= '0;
               k_q     <= '0;
               state_q <= S_ISSUE;
               rd_en_q <= 1'b1;
               clr_q   <= 1'b1;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ibfp_q  <= smax_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // Error detection sits after the start clear so a coincident fault still flags.
         if (bf_oact && ((state_q == S_IDLE) || (ret_q >= HALF) ||
                         (bf_octrl[1] && (ret_q != RET_LAST))))
            err_q <= 1'b1;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign stage      = stage_q;
   assign rd_en      = rd_en_q;
   assign bf_clr_bfp = clr_q;
   assign bf_ibfp    = ibfp_q;
   assign bf_iact    = act_q[RD_LATENCY-1];
   assign bf_ictrl   = ctrl_q[RD_LATENCY-1];
   assign bf_addr    = kd_q[RD_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
//   Two instances: a small FFT_N=3 / RD_LATENCY=1 sequencer checked against a
//   table of literal address/ctrl/BFP vectors plus hand-written abort and error
//   sequences, and an FFT_N=10 / RD_LATENCY=3 sequencer driven by a core model
//   with random return latency and random widths, checked against an
//   arithmetic reference model.
module tb_fft_stage_sequencer;
   localparam int AN = 3, AL = 1, BN = 10, BL = 3, W = 5, BH = 512;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // Instance A signals
   logic a_start, a_busy, a_done, a_err, a_rd_en, a_iact, a_clr, a_oact, a_wr_en;
   logic [AN-1:0] a_stage, a_rda, a_rdb, a_wra, a_wrb;
   logic [AN-2:0] a_tw, a_baddr, a_oaddr;
   logic [1:0]    a_ictrl, a_octrl;
   logic [W-1:0]  a_ibfp, a_mbw;

   // Instance B signals
   logic b_start, b_busy, b_done, b_err, b_rd_en, b_iact, b_clr, b_oact, b_wr_en;
   logic [BN-1:0] b_stage, b_rda, b_rdb, b_wra, b_wrb;
   logic [BN-2:0] b_tw, b_baddr, b_oaddr;
   logic [1:0]    b_ictrl, b_octrl;
   logic [W-1:0]  b_ibfp, b_mbw;

   fft_stage_sequencer #(.FFT_N(AN), .FFT_MAX_BIT_WIDTH(W), .RD_LATENCY(AL)) dut_a (
      .clk(clk), .reset(rst_n), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
      .stage(a_stage), .rd_en(a_rd_en), .rd_addr_a(a_rda), .rd_addr_b(a_rdb), .tw_addr(a_tw),
      .bf_iact(a_iact), .bf_ictrl(a_ictrl), .bf_addr(a_baddr), .bf_clr_bfp(a_clr),
      .bf_ibfp(a_ibfp), .bf_oact(a_oact), .bf_octrl(a_octrl), .bf_oaddr(a_oaddr),
      .bf_max_bit_width(a_mbw), .wr_en(a_wr_en), .wr_addr_a(a_wra), .wr_addr_b(a_wrb));

   fft_stage_sequencer #(.FFT_N(BN), .FFT_MAX_BIT_WIDTH(W), .RD_LATENCY(BL)) dut_b (
      .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
      .stage(b_stage), .rd_en(b_rd_en), .rd_addr_a(b_rda), .rd_addr_b(b_rdb), .tw_addr(b_tw),
      .bf_iact(b_iact), .bf_ictrl(b_ictrl), .bf_addr(b_baddr), .bf_clr_bfp(b_clr),
      .bf_ibfp(b_ibfp), .bf_oact(b_oact), .bf_octrl(b_octrl), .bf_oaddr(b_oaddr),
      .bf_max_bit_width(b_mbw), .wr_en(b_wr_en), .wr_addr_a(b_wra), .wr_addr_b(b_wrb));

   typedef struct { int w; int stage; int a; int b; int tw; int ctrl; int ibfp; } vec_t;
   typedef struct { int due; int ctrl; int addr; int w; } ret_t;
   typedef struct { int stage; int a; int b; int tw; int ibfp; } rd_t;
   typedef struct { int ctrl; int k; } is_t;

   vec_t tv[12];
   ret_t qa[$], qb[$];
   rd_t  rdlog[$];
   is_t  islog[$];
   int   wrlog_a[$], wrlog_b[$];

   int total = 0, bad = 0;
   int cyc = 0;
   int a_hist = 0, a_clr_cnt = 0, a_done_cnt = 0, a_busy_at_done = 0, a_wseq = 0;
   bit inj_a = 1'b0;
   int b_hist = 0, b_nrd = 0, b_niss = 0, b_nret = 0, b_nclr = 0, b_done_cnt = 0, b_last_due = 0;
   int b_bad_rd = 0, b_bad_lag = 0, b_bad_is = 0, b_bad_wr = 0;
   int b_smax[BN];
   int b_cnt_stage[BN];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: observe both DUTs at the falling edge, then drive the core returns.
   task automatic step();
      rd_t r; is_t s; ret_t t;
      int sg, k, span, ea, eb, et, j, w;
      @(negedge clk);
      cyc++;
      // ---- instance A observation
      a_hist = (a_hist << 1) | int'(a_rd_en);
      if (a_rd_en) begin
         r.stage = int'(a_stage); r.a = int'(a_rda); r.b = int'(a_rdb);
         r.tw = int'(a_tw); r.ibfp = int'(a_ibfp);
         rdlog.push_back(r);
      end
      if (a_iact || a_hist[AL]) chk("a_iact_lag", a_iact, a_hist[AL]);
      if (a_iact) begin
         s.ctrl = int'(a_ictrl); s.k = int'(a_baddr);
         islog.push_back(s);
         t.due = cyc + 2; t.ctrl = int'(a_ictrl); t.addr = int'(a_baddr);
         t.w = tv[a_wseq % 12].w;
         a_wseq++;
         qa.push_back(t);
      end
      if (a_wr_en) begin
         wrlog_a.push_back(int'(a_wra));
         wrlog_b.push_back(int'(a_wrb));
      end
      if (a_clr) a_clr_cnt++;
      if (a_done) begin
         a_done_cnt++;
         a_busy_at_done = int'(a_busy);
      end
      // ---- instance B observation against the arithmetic model
      b_hist = (b_hist << 1) | int'(b_rd_en);
      if (b_rd_en) begin
         sg = b_nrd / BH; k = b_nrd % BH; span = 1 << sg;
         ea = (k / span) * 2 * span + (k % span); eb = ea + span;
         et = (k % span) * (1 << (BN - 1 - sg));
         if (int'(b_stage) != sg || int'(b_rda) != ea || int'(b_rdb) != eb || int'(b_tw) != et)
            b_bad_rd++;
         if (int'(b_stage) < BN) b_cnt_stage[b_stage]++;
         b_nrd++;
      end
      if (int'(b_iact) != ((b_hist >> BL) & 1)) b_bad_lag++;
      if (b_iact) begin
         j = b_niss; k = j % BH;
         if (int'(b_ictrl) != ((k == BH - 1) ? 2 : 0) + ((k == 0) ? 1 : 0) || int'(b_baddr) != k)
            b_bad_is++;
         w = int'($urandom_range(0, 31));
         if (j / BH < BN && w > b_smax[j / BH]) b_smax[j / BH] = w;
         t.due = cyc + int'($urandom_range(1, 4));
         if (t.due <= b_last_due) t.due = b_last_due + 1;
         b_last_due = t.due;
         t.ctrl = int'(b_ictrl); t.addr = int'(b_baddr); t.w = w;
         qb.push_back(t);
         b_niss++;
      end
      if (b_wr_en) begin
         sg = b_nret / BH; k = int'(b_oaddr); span = 1 << sg;
         ea = (k / span) * 2 * span + (k % span); eb = ea + span;
         if (int'(b_wra) != ea || int'(b_wrb) != eb) b_bad_wr++;
         b_nret++;
      end
      if (b_clr) begin
         chk("b_ibfp_at_stage_start", b_ibfp, (b_nclr == 0) ? 0 : b_smax[b_nclr - 1]);
         b_nclr++;
      end
      if (b_done) begin
         b_done_cnt++;
         chk("b_busy_with_done", b_busy, 0);
      end
      // ---- core models drive results for the next rising edge
      a_oact = 1'b0; a_octrl = '0; a_oaddr = '0; a_mbw = '0;
      if (qa.size() > 0 && qa[0].due <= cyc) begin
         t = qa.pop_front();
         a_oact = 1'b1; a_octrl = t.ctrl[1:0]; a_oaddr = t.addr[AN-2:0]; a_mbw = t.w[W-1:0];
      end else if (inj_a) begin
         a_oact = 1'b1;
      end
      inj_a = 1'b0;
      b_oact = 1'b0; b_octrl = '0; b_oaddr = '0; b_mbw = '0;
      if (qb.size() > 0 && qb[0].due <= cyc) begin
         t = qb.pop_front();
         b_oact = 1'b1; b_octrl = t.ctrl[1:0]; b_oaddr = t.addr[BN-2:0]; b_mbw = t.w[W-1:0];
      end
   endtask

   task automatic clear_a_logs();
      rdlog.delete(); islog.delete(); wrlog_a.delete(); wrlog_b.delete();
      a_clr_cnt = 0; a_done_cnt = 0; a_busy_at_done = 0; a_wseq = 0;
   endtask

   // Full run on instance A; optionally pulses start mid stage 1, or injects one
   // extra return right after the last return of stage 0. Always presents a start
   // coincident with done and confirms it is ignored.
   task automatic run_a(input bit mid_start, input bit err_inj);
      int d0; bit pulsed, injd;
      d0 = a_done_cnt; pulsed = 1'b0; injd = 1'b0;
      a_start = 1'b1; step(); a_start = 1'b0;
      for (int i = 0; i < 300 && a_done_cnt == d0; i++) begin
         step();
         a_start = 1'b0;
         if (mid_start && !pulsed && a_stage == 1 && a_rd_en) begin
            a_start = 1'b1; pulsed = 1'b1;
         end
         if (err_inj && !injd && a_oact && a_octrl[1]) begin
            chk("a_err_clear_after_start", a_err, 0);
            inj_a = 1'b1; injd = 1'b1;
         end
      end
      chk("a_run_done_seen", a_done_cnt - d0, 1);
      chk("a_busy_with_done", a_busy_at_done, 0);
      a_start = 1'b1; step(); a_start = 1'b0;
      step(); step();
      chk("a_start_at_done_ignored", {a_busy, a_rd_en}, 0);
   endtask

   initial begin
      a_start = 0; a_oact = 0; a_octrl = '0; a_oaddr = '0; a_mbw = '0;
      b_start = 0; b_oact = 0; b_octrl = '0; b_oaddr = '0; b_mbw = '0;
      for (int i = 0; i < BN; i++) begin b_smax[i] = 0; b_cnt_stage[i] = 0; end
      tv[0]  = '{3, 0, 0, 1, 0, 1, 0};  tv[1]  = '{7, 0, 2, 3, 0, 0, 0};
      tv[2]  = '{2, 0, 4, 5, 0, 0, 0};  tv[3]  = '{5, 0, 6, 7, 0, 2, 0};
      tv[4]  = '{1, 1, 0, 2, 0, 1, 7};  tv[5]  = '{1, 1, 1, 3, 2, 0, 7};
      tv[6]  = '{4, 1, 4, 6, 0, 0, 7};  tv[7]  = '{1, 1, 5, 7, 2, 2, 7};
      tv[8]  = '{2, 2, 0, 4, 0, 1, 4};  tv[9]  = '{6, 2, 1, 5, 1, 0, 4};
      tv[10] = '{0, 2, 2, 6, 2, 0, 4};  tv[11] = '{3, 2, 3, 7, 3, 2, 4};

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("a_outputs_in_reset", |{a_busy, a_done, a_err, a_stage, a_rd_en, a_rda, a_rdb, a_tw,
          a_iact, a_ictrl, a_baddr, a_clr, a_ibfp, a_wr_en, a_wra, a_wrb}, 0);
      chk("b_outputs_in_reset", |{b_busy, b_done, b_err, b_stage, b_rd_en, b_rda, b_rdb, b_tw,
          b_iact, b_ictrl, b_baddr, b_clr, b_ibfp, b_wr_en, b_wra, b_wrb}, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Single run with an ignored start mid stage 1, compared against the table
      clear_a_logs();
      run_a(1'b1, 1'b0);
      chk("a_issue_count", rdlog.size(), 12);
      chk("a_iact_count", islog.size(), 12);
      chk("a_write_count", wrlog_a.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < rdlog.size()) begin
            chk("a_rd_stage", rdlog[i].stage, tv[i].stage);
            chk("a_rd_addr_a", rdlog[i].a, tv[i].a);
            chk("a_rd_addr_b", rdlog[i].b, tv[i].b);
            chk("a_tw_addr", rdlog[i].tw, tv[i].tw);
            chk("a_ibfp", rdlog[i].ibfp, tv[i].ibfp);
         end
         if (i < islog.size()) begin
            chk("a_ictrl", islog[i].ctrl, tv[i].ctrl);
            chk("a_bf_addr", islog[i].k, i % 4);
         end
         if (i < wrlog_a.size()) begin
            chk("a_wr_addr_a", wrlog_a[i], tv[i].a);
            chk("a_wr_addr_b", wrlog_b[i], tv[i].b);
         end
      end
      chk("a_clr_pulses", a_clr_cnt, 3);
      chk("a_done_pulses", a_done_cnt, 1);
      chk("a_final_ibfp", a_ibfp, 6);
      chk("a_err_clean_run", a_err, 0);

      // Abort by reset in the middle of stage 1
      clear_a_logs();
      a_start = 1'b1; step(); a_start = 1'b0;
      for (int i = 0; i < 100 && !(a_stage == 1 && a_rd_en); i++) step();
      chk("a_reached_stage1", a_stage, 1);
      #2 rst_n = 1'b0;
      a_oact = 1'b0; qa.delete(); a_hist = 0;
      #1;
      chk("a_outputs_async_reset", |{a_busy, a_done, a_err, a_stage, a_rd_en, a_rda, a_rdb, a_tw,
          a_iact, a_ictrl, a_baddr, a_clr, a_ibfp, a_wr_en, a_wra, a_wrb}, 0);
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("a_no_done_after_abort", a_done_cnt, 0);
      chk("a_idle_after_abort", a_busy, 0);
      clear_a_logs();
      run_a(1'b0, 1'b0);
      chk("a_restart_issue_count", rdlog.size(), 12);
      if (rdlog.size() > 0) begin
         chk("a_restart_stage", rdlog[0].stage, 0);
         chk("a_restart_addr_b", rdlog[0].b, 1);
      end
      chk("a_restart_clr_pulses", a_clr_cnt, 3);

      // Errors: spurious return in IDLE, then an extra return in stage 0
      inj_a = 1'b1; step(); step();
      chk("a_err_idle_return", a_err, 1);
      for (int i = 0; i < 4; i++) step();
      chk("a_err_held_in_idle", a_err, 1);
      clear_a_logs();
      run_a(1'b0, 1'b1);
      chk("a_err_extra_return_sticky", a_err, 1);

      // Latency sweep on the large instance with random widths and return latency
      b_start = 1'b1; step(); b_start = 1'b0;
      for (int i = 0; i < 8000 && b_done_cnt == 0; i++) step();
      for (int i = 0; i < 20; i++) step();
      chk("b_done_once", b_done_cnt, 1);
      chk("b_read_addr_mismatches", b_bad_rd, 0);
      chk("b_iact_lag_mismatches", b_bad_lag, 0);
      chk("b_issue_ctrl_mismatches", b_bad_is, 0);
      chk("b_write_addr_mismatches", b_bad_wr, 0);
      chk("b_total_returns", b_nret, BN * BH);
      chk("b_clr_pulses", b_nclr, BN);
      for (int i = 0; i < BN; i++) chk("b_issues_per_stage", b_cnt_stage[i], BH);
      chk("b_final_ibfp", b_ibfp, b_smax[BN - 1]);
      chk("b_err_clean_run", b_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
